mem_arbiter: RTL and testbench

- Shares the single RAM port between the datapath's instruction-fetch and data-memory requests.
- Sits between the datapath/request unit and the RAM model and is a clocked FSM.
- Data requests get default priority. A starvation counter guarantees that fetches still make progress.
- Returns registered load data with one-cycle ihit/dhit pulses, and flags RAM errors and timeouts.

---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and data accesses.
// Data wins by default; a saturating starvation counter forces a fetch through.
module mem_arbiter #(
  parameter int unsigned MAXSTARVE = 4,
  parameter int unsigned TIMEOUT   = 64,
  parameter logic [31:0] ERRWORD   = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        err,
  output logic        busy
);

  localparam int SW = ($clog2(MAXSTARVE + 1) < 3) ? 3 : $clog2(MAXSTARVE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] MAX_S    = SW'(MAXSTARVE);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC, RESP} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   iload_q, iload_d;
  logic [31:0]   dload_q, dload_d;
  logic          err_q, err_d;
  logic          side_q, side_d;   // 1: data side is being served
  logic          dreq;
  logic          abort;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == MAX_S) ? v : v + SW'(1);
  endfunction

  assign dreq  = dREN | dWEN;
  assign abort = (ramstate == RAM_ERROR) || (tmo_q == TMO_LAST);

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    tmo_d    = tmo_q;
    iload_d  = iload_q;
    dload_d  = dload_q;
    err_d    = err_q;
    side_d   = side_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    ihit     = 1'b0;
    dhit     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dreq && ((starve_q < MAX_S) || !iREN)) begin
          state_d = D_ACC;
          side_d  = 1'b1;
          tmo_d   = '0;
          if (iREN) starve_d = sat_inc(starve_q);
        end else if (iREN) begin
          state_d  = I_ACC;
          side_d   = 1'b0;
          tmo_d    = '0;
          starve_d = '0;
        end
      end
      I_ACC: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (ramstate == RAM_ACCESS) begin
          iload_d = ramload;
          state_d = RESP;
        end else if (abort) begin
          iload_d = ERRWORD;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      D_ACC: begin
        ramaddr = daddr;
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else begin
          ramREN = 1'b1;
        end
        // Writes never touch dload, even when aborted.
        if (ramstate == RAM_ACCESS) begin
          if (!dWEN) dload_d = ramload;
          state_d = RESP;
        end else if (abort) begin
          if (!dWEN) dload_d = ERRWORD;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RESP: begin
        ihit    = ~side_q;
        dhit    = side_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      starve_q <= '0;
      tmo_q    <= '0;
      iload_q  <= '0;
      dload_q  <= '0;
      err_q    <= 1'b0;
      side_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
      iload_q  <= iload_d;
      dload_q  <= dload_d;
      err_q    <= err_d;
      side_q   <= side_d;
    end
  end

  assign iload = iload_q;
  assign dload = dload_q;
  assign err   = err_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch/data arbitration, starvation, writes,
// timeout and RAM error aborts, and reset in the middle of an access.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        ramREN, ramWEN, ihit, dhit, err, busy;
  logic [31:0] ramaddr, ramstore, iload, dload;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] FREE = 2'd0, BUSYS = 2'd1, ACC = 2'd2, ERR = 2'd3;

  mem_arbiter dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ramload(ramload), .ramstate(ramstate),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload), .err(err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    int dcnt;
    bit seen;
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
    tick(); tick();
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_hits", {ihit, dhit}, 0);
    chk("rst_loads", iload | dload, 0);
    chk("rst_err_busy", {err, busy}, 0);
    RST = 1'b0;

    // Fetch with RAM ready on the second access cycle
    iREN = 1; iaddr = 32'h40; ramstate = BUSYS;
    tick();
    chk("i1_ramREN", ramREN, 1);
    chk("i1_ramaddr", ramaddr, 32'h40);
    chk("i1_busy", busy, 1);
    chk("i1_noihit_c2", ihit, 0);
    tick();
    chk("i1_noihit_c3", ihit, 0);
    ramstate = ACC; ramload = 32'h2401000A;
    tick();
    chk("i1_ihit", ihit, 1);
    chk("i1_iload", iload, 32'h2401000A);
    chk("i1_resp_ramREN", ramREN, 0);
    iREN = 0; ramstate = FREE;
    tick();
    chk("i1_ihit_single", ihit, 0);
    chk("i1_idle", busy, 0);

    // Simultaneous requests: data first, then fetch
    iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h100;
    ramstate = ACC; ramload = 32'h11112222;
    tick();
    chk("both_daddr", ramaddr, 32'h100);
    chk("both_dren", {ramREN, ramWEN}, 2'b10);
    tick();
    chk("both_dhit", {ihit, dhit}, 2'b01);
    chk("both_dload", dload, 32'h11112222);
    dREN = 0; ramload = 32'h33334444;
    tick();
    chk("both_idle", busy, 0);
    tick();
    chk("both_iaddr", ramaddr, 32'h80);
    tick();
    chk("both_ihit", {ihit, dhit}, 2'b10);
    chk("both_iload", iload, 32'h33334444);
    iREN = 0;
    tick();

    // Continuous contention: MAXSTARVE data grants, then a fetch
    iREN = 1; dREN = 1;
    dcnt = 0; seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (dhit) dcnt++;
      if (ihit) begin
        seen = 1;
        break;
      end
    end
    chk("starve_ihit_seen", seen, 1);
    chk("starve_dhits", dcnt, 4);
    iREN = 0; dREN = 0;
    tick();

    // Write: dWEN wins over dREN, dload untouched
    dWEN = 1; dREN = 1; daddr = 32'h200; dstore = 32'hDEADBEEF;
    ramstate = BUSYS; ramload = 32'h55555555;
    tick();
    chk("wr_en", {ramWEN, ramREN}, 2'b10);
    chk("wr_store", ramstore, 32'hDEADBEEF);
    chk("wr_addr", ramaddr, 32'h200);
    ramstate = ACC;
    tick();
    chk("wr_dhit", dhit, 1);
    chk("wr_dload", dload, 32'h33334444);
    dWEN = 0; dREN = 0;
    tick();

    // RAM ERROR during a fetch
    iREN = 1; iaddr = 32'h44; ramstate = BUSYS;
    tick(); tick();
    chk("er_pre_err", err, 0);
    ramstate = ERR;
    tick();
    chk("er_ihit", ihit, 1);
    chk("er_iload", iload, 32'hBAD1BAD1);
    chk("er_err", err, 1);
    iREN = 0; ramstate = FREE;
    tick();
    chk("er_err_sticky", err, 1);

    // Reset in the middle of a data access
    dREN = 1; daddr = 32'h300; ramstate = BUSYS;
    tick();
    chk("rd_in_dacc", {busy, ramREN}, 2'b11);
    RST = 1;
    tick();
    chk("rd_busy", busy, 0);
    chk("rd_ram", {ramREN, ramWEN, ramaddr}, 0);
    chk("rd_nohit", {ihit, dhit}, 0);
    chk("rd_err", err, 0);
    chk("rd_iload", iload, 0);
    RST = 0; dREN = 0;
    tick();
    chk("rd_nohit_after", {ihit, dhit, busy}, 0);

    // Timeout: BUSY held for the whole access window
    iREN = 1; iaddr = 32'h48; ramstate = BUSYS;
    tick();
    cnt = 0;
    while (ihit !== 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("to_cycles", cnt, 64);
    chk("to_ihit", ihit, 1);
    chk("to_iload", iload, 32'hBAD1BAD1);
    chk("to_err", err, 1);
    iREN = 0; ramstate = FREE;
    tick();
    chk("to_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
